// File: rtl/alsu_pipe.sv
// Handshaked ALSU: one registered operation per transfer, single-cycle execute,
// iterative signed shift-add multiply. Optional error counter: ALSU_PIPE_ERR_CNT_EN.
module alsu_pipe #(
    parameter int WIDTH          = 3,
    parameter     INPUT_PRIORITY = "A",
    parameter int LED_W          = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 cin,
    input  logic                 serial_in,
    input  logic                 direction,
    input  logic                 red_op_A,
    input  logic                 red_op_B,
    input  logic                 bypass_A,
    input  logic                 bypass_B,
    input  logic [2:0]           opcode,
    output logic [2*WIDTH-1:0]   out,
    output logic                 out_valid,
    output logic                 err,
    output logic [LED_W-1:0]     leds
`ifdef ALSU_PIPE_ERR_CNT_EN
    ,
    output logic [15:0]          err_cnt
`endif
);

    localparam int OW     = 2 * WIDTH;
    localparam int CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam bit PRIO_B = (INPUT_PRIORITY == "B");

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_t;
    state_t state_reg, state_next;

    logic             xfer, capt_mul, mul_last, invalid;
    logic [WIDTH-1:0] a_reg, b_reg, red_sel;
    logic             cin_reg, sin_reg, dir_reg;
    logic             red_a_reg, red_b_reg, byp_a_reg, byp_b_reg;
    logic [2:0]       opc_reg;
    logic [CW-1:0]    cnt_reg;
    logic [OW-1:0]    a_ext, b_ext, byp_sel, term, acc_reg, acc_next;
    logic [OW-1:0]    exec_result, out_reg;
    logic             out_valid_reg, err_reg;
    logic [LED_W-1:0] leds_reg;

    // Only a plain, unbypassed multiply goes iterative; invalid or bypassed MULs finish in one cycle.
    assign capt_mul = (opcode == 3'd3) && !(red_op_A || red_op_B) && !bypass_A && !bypass_B;

    assign a_ext = {{WIDTH{a_reg[WIDTH-1]}}, a_reg};
    assign b_ext = {{WIDTH{b_reg[WIDTH-1]}}, b_reg};

    always_comb begin
        state_next = state_reg;
        in_ready   = (state_reg != S_MUL);
        xfer       = in_valid && in_ready;
        case (state_reg)
            S_IDLE, S_EXEC: state_next = xfer ? (capt_mul ? S_MUL : S_EXEC) : S_IDLE;
            S_MUL:          state_next = mul_last ? S_IDLE : S_MUL;
            default:        state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= S_IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        invalid = ((red_a_reg || red_b_reg) && (opc_reg[2:1] != 2'b00)) || (opc_reg[2:1] == 2'b11);
        red_sel = (red_a_reg && red_b_reg) ? (PRIO_B ? b_reg : a_reg) : (red_a_reg ? a_reg : b_reg);
        byp_sel = (byp_a_reg && byp_b_reg) ? (PRIO_B ? b_ext : a_ext) : (byp_a_reg ? a_ext : b_ext);
        exec_result = '0;
        if (invalid) begin
            exec_result = '0;
        end else if (byp_a_reg || byp_b_reg) begin
            exec_result = byp_sel;
        end else begin
            case (opc_reg)
                3'd0: exec_result = (red_a_reg || red_b_reg) ? {{(OW-1){1'b0}}, |red_sel} : (a_ext | b_ext);
                3'd1: exec_result = (red_a_reg || red_b_reg) ? {{(OW-1){1'b0}}, ^red_sel} : (a_ext ^ b_ext);
                3'd2: exec_result = a_ext + b_ext + {{(OW-1){1'b0}}, cin_reg};
                3'd4: exec_result = dir_reg ? {out_reg[OW-2:0], sin_reg} : {sin_reg, out_reg[OW-1:1]};
                3'd5: exec_result = dir_reg ? {out_reg[OW-2:0], out_reg[OW-1]} : {out_reg[0], out_reg[OW-1:1]};
                default: exec_result = '0;
            endcase
        end
        // The multiplier's sign bit carries negative weight, so the last partial product is subtracted.
        mul_last = (cnt_reg == CW'(WIDTH - 1));
        term     = b_reg[cnt_reg] ? (a_ext << cnt_reg) : '0;
        acc_next = mul_last ? (acc_reg - term) : (acc_reg + term);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_reg         <= '0;
            b_reg         <= '0;
            cin_reg       <= 1'b0;
            sin_reg       <= 1'b0;
            dir_reg       <= 1'b0;
            red_a_reg     <= 1'b0;
            red_b_reg     <= 1'b0;
            byp_a_reg     <= 1'b0;
            byp_b_reg     <= 1'b0;
            opc_reg       <= '0;
            cnt_reg       <= '0;
            acc_reg       <= '0;
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
            leds_reg      <= '0;
        end else begin
            out_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
            if (state_reg == S_EXEC) begin
                out_reg       <= exec_result;
                out_valid_reg <= 1'b1;
                err_reg       <= invalid;
                leds_reg      <= invalid ? ~leds_reg : '0;
            end
            if (state_reg == S_MUL) begin
                acc_reg <= acc_next;
                cnt_reg <= cnt_reg + CW'(1);
                if (mul_last) begin
                    cnt_reg       <= '0;
                    out_reg       <= acc_next;
                    out_valid_reg <= 1'b1;
                    leds_reg      <= '0;
                end
            end
            if (xfer) begin
                a_reg     <= A;
                b_reg     <= B;
                cin_reg   <= cin;
                sin_reg   <= serial_in;
                dir_reg   <= direction;
                red_a_reg <= red_op_A;
                red_b_reg <= red_op_B;
                byp_a_reg <= bypass_A;
                byp_b_reg <= bypass_B;
                opc_reg   <= opcode;
                cnt_reg   <= '0;
                acc_reg   <= '0;
            end
        end
    end

    assign out       = out_reg;
    assign out_valid = out_valid_reg;
    assign err       = err_reg;
    assign leds      = leds_reg;

`ifdef ALSU_PIPE_ERR_CNT_EN
    logic [15:0] err_cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err_cnt_reg <= '0;
        else if ((state_reg == S_EXEC) && invalid && (err_cnt_reg != 16'hFFFF))
            err_cnt_reg <= err_cnt_reg + 16'd1;
    end

    assign err_cnt = err_cnt_reg;
`else
    // Error counter not built in this configuration.
`endif

endmodule

// File: tb/tb_alsu_pipe.sv
// Self-checking bench for alsu_pipe (WIDTH=3, INPUT_PRIORITY="B"): directed steps
// followed by random operations checked against an arithmetic reference model.
module tb_alsu_pipe;

    localparam int W      = 3;
    localparam int OW     = 2 * W;
    localparam     PRIO   = "B";
    localparam bit PRIO_B = (PRIO == "B");
    localparam int MASK   = (2 ** OW) - 1;

    typedef struct {
        int opc;
        int a;
        int b;
        bit cin, sin, dir, ra, rb, ba, bb;
    } op_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  A = '0, B = '0;
    logic          cin = 1'b0, serial_in = 1'b0, direction = 1'b0;
    logic          red_op_A = 1'b0, red_op_B = 1'b0, bypass_A = 1'b0, bypass_B = 1'b0;
    logic [2:0]    opcode = '0;
    logic [OW-1:0] out;
    logic          out_valid, err;
    logic [15:0]   leds;
`ifdef ALSU_PIPE_ERR_CNT_EN
    logic [15:0]   err_cnt;
`endif

    int            n_vec = 0;
    int            n_err = 0;
    int            m_out = 0;
    logic [15:0]   m_leds = '0;
    int            m_errs = 0;
    logic [OW-1:0] last_out;

    alsu_pipe #(.WIDTH(W), .INPUT_PRIORITY(PRIO), .LED_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .cin(cin), .serial_in(serial_in), .direction(direction),
        .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
        .opcode(opcode), .out(out), .out_valid(out_valid), .err(err), .leds(leds)
`ifdef ALSU_PIPE_ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic op_t mk(int opc, int a, int b, bit cin_v = 0, bit sin_v = 0, bit dir_v = 0,
                               bit ra = 0, bit rb = 0, bit ba = 0, bit bb = 0);
        op_t o;
        o.opc = opc; o.a = a; o.b = b; o.cin = cin_v; o.sin = sin_v; o.dir = dir_v;
        o.ra = ra; o.rb = rb; o.ba = ba; o.bb = bb;
        return o;
    endfunction

    task automatic drive(input op_t o);
        A = o.a[W-1:0]; B = o.b[W-1:0]; cin = o.cin; serial_in = o.sin; direction = o.dir;
        red_op_A = o.ra; red_op_B = o.rb; bypass_A = o.ba; bypass_B = o.bb; opcode = o.opc[2:0];
    endtask

    // Reference model: integer arithmetic on the operation rules, result taken modulo 2**OW.
    task automatic model_step(input op_t o, output logic [OW-1:0] eout, output logic eerr,
                              output logic [15:0] eleds, output int lat);
        int r, u, sel, pc;
        bit inv;
        inv = ((o.ra || o.rb) && o.opc >= 2) || o.opc >= 6;
        lat = 1;
        r = 0;
        if (inv) r = 0;
        else if (o.ba && o.bb) r = PRIO_B ? o.b : o.a;
        else if (o.ba) r = o.a;
        else if (o.bb) r = o.b;
        else begin
            case (o.opc)
                0, 1: begin
                    if (o.ra || o.rb) begin
                        sel = (o.ra && o.rb) ? (PRIO_B ? o.b : o.a) : (o.ra ? o.a : o.b);
                        u = sel & ((2 ** W) - 1);
                        pc = 0;
                        for (int i = 0; i < W; i++) pc += (u >> i) & 1;
                        r = (o.opc == 0) ? int'(pc != 0) : pc % 2;
                    end else begin
                        r = (o.opc == 0) ? (o.a | o.b) : (o.a ^ o.b);
                    end
                end
                2: r = o.a + o.b + int'(o.cin);
                3: begin r = o.a * o.b; lat = W; end
                4: r = o.dir ? (m_out * 2 + int'(o.sin)) : (m_out / 2 + int'(o.sin) * (2 ** (OW - 1)));
                5: r = o.dir ? (m_out * 2 + m_out / (2 ** (OW - 1))) : (m_out / 2 + (m_out % 2) * (2 ** (OW - 1)));
                default: r = 0;
            endcase
        end
        r = r & MASK;
        m_out = r;
        eout = r[OW-1:0];
        eerr = inv;
        m_leds = inv ? ~m_leds : 16'h0000;
        eleds = m_leds;
        if (inv && m_errs < 65535) m_errs++;
    endtask

    task automatic run_op(input op_t o, input string tag);
        logic [OW-1:0] eout;
        logic          eerr;
        logic [15:0]   eleds;
        int            lat, n;
        @(negedge clk);
        chk({tag, ":idle_valid"}, out_valid, 0);
        chk({tag, ":ready"}, in_ready, 1);
        model_step(o, eout, eerr, eleds, lat);
        drive(o);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (lat == 1) in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < lat + 4) begin
            if (lat > 1) chk({tag, ":busy"}, in_ready, 0);
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        chk({tag, ":latency"}, n, lat);
        chk({tag, ":out"}, out, eout);
        chk({tag, ":err"}, err, eerr);
        chk({tag, ":leds"}, leds, eleds);
        chk({tag, ":ready_after"}, in_ready, 1);
        last_out = out;
        $display("op %-10s opc=%0d A=%0d B=%0d -> out=%b err=%b leds=%h", tag, o.opc, o.a, o.b, out, err, leds);
    endtask

    initial begin
        logic [OW-1:0] e1, e2;
        logic          r1, r2;
        logic [15:0]   l1, l2;
        int            lt;
        op_t           o;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst:out", out, 0);
        chk("rst:out_valid", out_valid, 0);
        chk("rst:err", err, 0);
        chk("rst:leds", leds, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst:in_ready", in_ready, 1);

        run_op(mk(2, 3, 3, 1), "add337");
        chk("add337:const", last_out, 6'd7);

        run_op(mk(3, -4, 3), "mul-4x3");
        chk("mul:const", last_out, 6'b110100);

        // Two invalid ops back to back at full throughput
        model_step(mk(6, 1, 2), e1, r1, l1, lt);
        model_step(mk(7, 2, 1), e2, r2, l2, lt);
        @(negedge clk);
        drive(mk(6, 1, 2));
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drive(mk(7, 2, 1));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b1:valid", out_valid, 1);
        chk("b2b1:err", err, r1);
        chk("b2b1:leds", leds, l1);
        chk("b2b1:leds_const", leds, 16'hFFFF);
        $display("op b2b1       out=%b err=%b leds=%h", out, err, leds);
        @(negedge clk);
        chk("b2b2:valid", out_valid, 1);
        chk("b2b2:err", err, r2);
        chk("b2b2:leds", leds, l2);
        chk("b2b2:leds_const", leds, 16'h0000);
        $display("op b2b2       out=%b err=%b leds=%h", out, err, leds);

        run_op(mk(0, 1, 2), "or12");
        chk("or12:const", last_out, 6'd3);

        run_op(mk(6, 0, 0), "inval");
        run_op(mk(4, 0, 0, 0, 1, 1), "shl1");
        chk("shl1:const", last_out, 6'b000001);
        run_op(mk(5, 0, 0, 0, 0, 0), "rotr");
        chk("rotr:const", last_out, 6'b100000);
        run_op(mk(4, 0, 0, 0, 1, 1), "shl1b");
        chk("shl1b:const", last_out, 6'b000001);

        run_op(mk(0, -2, 1, 0, 0, 0, 0, 0, 1, 1), "byp_both");
        chk("byp_both:const", last_out, 6'd1);
        run_op(mk(2, 1, 1, 0, 0, 0, 1, 0), "red_add");
        chk("red_add:const", last_out, 6'd0);

        for (int i = 0; i < 60; i++) begin
            o = mk(int'($urandom_range(7)), int'($urandom_range(7)) - 4, int'($urandom_range(7)) - 4,
                   1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                   $urandom_range(3) == 0, $urandom_range(3) == 0,
                   $urandom_range(4) == 0, $urandom_range(4) == 0);
            run_op(o, "random");
        end

`ifdef ALSU_PIPE_ERR_CNT_EN
        chk("err_cnt", err_cnt, 16'(m_errs));
`endif

        // Abort a multiply with reset one cycle after the transfer
        run_op(mk(7, 0, 0), "pre_rst");
        @(negedge clk);
        drive(mk(3, 3, -3));
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("abort:busy", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("abort:out", out, 0);
        chk("abort:out_valid", out_valid, 0);
        chk("abort:err", err, 0);
        chk("abort:leds", leds, 0);
`ifdef ALSU_PIPE_ERR_CNT_EN
        chk("abort:err_cnt", err_cnt, 0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b1;
        m_out = 0;
        m_leds = '0;
        m_errs = 0;
        @(negedge clk);
        chk("abort:in_ready", in_ready, 1);
        chk("abort:no_pulse", out_valid, 0);
        chk("abort:out_hold", out, 0);
        $display("op abort      out=%b err=%b leds=%h ready=%b", out, err, leds, in_ready);

        run_op(mk(3, 2, -3), "post_mul");
        chk("post_mul:const", last_out, 6'b111010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alsu_pipe.md
# alsu_pipe

Parametrised, handshaked successor to the team's 3-bit ALSU. It registers one operation per accepted transfer and executes it in a single cycle, except multiply, which runs as an iterative signed shift-add over WIDTH cycles and back-pressures the source. It sits between the stimulus/register front-end and the result sink. It reports invalid operations through a result flag and blinking LEDs.

## Interface
- WIDTH, 3, signed operand width (≥2); result width OW = 2*WIDTH
- INPUT_PRIORITY, "A", operand chosen when both bypass or both red_op are set ("A" or "B")
- LED_W, 16, LED vector width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- in_valid  in  1  operation present
- in_ready  out  1  block can accept
- A, B  in  WIDTH  signed operands
- cin  in  1  carry-in for add (unsigned 0/1)
- serial_in, direction  in  1  shift input bit; 1 = left, 0 = right
- red_op_A, red_op_B, bypass_A, bypass_B  in  1  mode controls
- opcode  in  3  0 OR, 1 XOR, 2 ADD, 3 MUL, 4 SHIFT, 5 ROTATE, 6/7 invalid
- out  out  OW  signed result register
- out_valid  out  1  one-cycle pulse: out updated
- err  out  1  qualified by out_valid: the operation was invalid
- leds  out  LED_W  invalid indicator

## Operation
- Transfer: the block accepts an operation on a rising edge where in_valid && in_ready. Inputs are captured into stage-1 registers, and stage-1 valid is set.
- Invalid: (red_op_A|red_op_B) && opcode[2:1]!=0, or opcode[2:1]==2'b11. Result: out=0, err=1, and leds inverts.
- Any valid completed operation clears leds to 0. leds holds when no operation completes.
- Priority: invalid > bypass (both set: INPUT_PRIORITY operand) > bypass_A > bypass_B > opcode. Bypassed operands are sign-extended to OW.
- OR/XOR: red_op selects the reduction (|, ^) of the chosen operand, zero-extended, with INPUT_PRIORITY applied when both are set. Otherwise bitwise on operands sign-extended to OW.
- ADD: A + B + cin, signed, sign-extended to OW. No overflow is possible.
- MUL: exact signed product in OW bits.
- SHIFT: out <= {out[OW-2:0],serial_in} when direction=1, else {serial_in,out[OW-1:1]}.
- ROTATE: same as SHIFT, with the wrap-around bit in place of serial_in.
- SHIFT/ROTATE act on the current out register, whatever the last result was, including a zero from an invalid operation.
- FSM states:
  - IDLE: stage 1 empty; in_ready=1.
  - EXEC: single-cycle op in stage 1; in_ready=1. It completes on the next edge; a new transfer on that same edge stays in EXEC.
  - MUL: multiply in stage 1; in_ready=0; iteration counter runs 0..WIDTH-1. On the last count it writes out and goes to IDLE.
- Transitions: a transfer enters EXEC or MUL according to the captured opcode and modes. A multiply that is invalid or bypassed is a single-cycle op (EXEC).

## Timing
- Reset values: out=0, out_valid=0, err=0, leds=0, in_ready=1 (once released), FSM=IDLE, counter=0.
- Single-cycle op: transfer at edge N → out/out_valid/err valid after edge N+1. Full throughput, one op per cycle.
- MUL: transfer at edge N → in_ready low after N → result and out_valid after edge N+WIDTH → in_ready high after edge N+WIDTH.
- in_valid while in_ready=0 is ignored; the source holds the operation until it is accepted.
- out holds between completions.
- Reset asserted mid-multiply: aborts immediately. All outputs and state return to reset values, with no out_valid pulse.

## Configuration
- ALSU_PIPE_ERR_CNT_EN defined:
  - Adds output err_cnt (16 bits), reset 0.
  - Increments on each completion with err=1, saturating at 16'hFFFF.
- Undefined: no err_cnt port or logic.

## Test plan
- Reset then ADD A=3, B=3, cin=1 (WIDTH=3) → one cycle after transfer, out=7, out_valid=1, err=0, leds=0.
- MUL A=-4, B=3, WIDTH=3 → in_ready low for 3 cycles. out=-12 (6'b110100) after edge N+3. in_valid held high during busy is not accepted twice.
- Two back-to-back opcode 6 ops, then OR A=1, B=2 → err=1 twice, leds=FFFF then 0000, then out=3 with leds=0.
- Out=6'b000001, then ROTATE direction=0 → out=6'b100000. Then SHIFT direction=1, serial_in=1 → out=6'b000001.
- bypass_A=bypass_B=1, A=-2, B=1, INPUT_PRIORITY="B" → out=1. With red_op_A=1 and opcode=2 → err=1, out=0.
- rst low at cycle 1 of a MUL → all outputs 0 and in_ready=1 on release. With ALSU_PIPE_ERR_CNT_EN, err_cnt resets to 0.
